// File: rtl/plic_gateway_bank.sv
// Interrupt gateway bank: per-source IDLE/PENDING/CLAIMED lifecycle plus a lowest-ID-wins top selector.
// Define PLIC_GATEWAY_EDGE_EN for edge-triggered sources with a rearm bit; level-sensitive otherwise.
module plic_gateway_bank #(
  parameter int NSRC = 8,
  parameter int IDW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] io_src,
  input  logic            io_claim_valid,
  input  logic [IDW-1:0]  io_claim_id,
  input  logic            io_complete_valid,
  input  logic [IDW-1:0]  io_complete_id,
  output logic [NSRC-1:0] io_pending,
  output logic [NSRC-1:0] io_inflight,
  output logic            io_top_valid,
  output logic [IDW-1:0]  io_top_id
);

  // One-hot-ish encoding so pending/inflight are direct flop bits.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    CLAIMED = 2'b10
  } src_state_e;

  src_state_e      state_q [NSRC];
  src_state_e      state_d [NSRC];
  logic [NSRC-1:0] trigger;
  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] complete_hit;
  logic [IDW-1:0]  top_id_d;

  // IDs 0 and >NSRC never equal any i+1, so those strobes fall through untouched.
  for (genvar i = 0; i < NSRC; i++) begin : g_match
    assign claim_hit[i]    = io_claim_valid    && (io_claim_id    == IDW'(i + 1));
    assign complete_hit[i] = io_complete_valid && (io_complete_id == IDW'(i + 1));
  end

`ifdef PLIC_GATEWAY_EDGE_EN
  logic [NSRC-1:0] src_prev_q;
  logic [NSRC-1:0] rearm_q;
  logic [NSRC-1:0] rearm_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      src_prev_q <= '0;
      rearm_q    <= '0;
    end else begin
      src_prev_q <= io_src;
      rearm_q    <= rearm_d;
    end
  end

  assign trigger = io_src & ~src_prev_q;
`else
  assign trigger = io_src;
`endif

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      // NOTE: every combinational output is defaulted before the case so no path leaves it unassigned (no latch).
      state_d[i] = state_q[i];
`ifdef PLIC_GATEWAY_EDGE_EN
      rearm_d[i] = rearm_q[i];
`endif
      unique case (state_q[i])
        IDLE:    if (trigger[i]) state_d[i] = PENDING;
        PENDING: if (claim_hit[i]) state_d[i] = CLAIMED;
        CLAIMED: begin
`ifdef PLIC_GATEWAY_EDGE_EN
          // An edge seen while claimed is remembered and replayed on completion.
          if (complete_hit[i]) begin
            state_d[i] = (rearm_q[i] || trigger[i]) ? PENDING : IDLE;
            rearm_d[i] = 1'b0;
          end else if (trigger[i]) begin
            rearm_d[i] = 1'b1;
          end
`else
          if (complete_hit[i]) state_d[i] = IDLE;
`endif
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      io_pending[i]  = (state_q[i] == PENDING);
      io_inflight[i] = (state_q[i] == CLAIMED);
    end
  end

  // Scan high-to-low so the lowest pending index is the last writer.
  always_comb begin
    top_id_d = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (io_pending[i]) top_id_d = IDW'(i + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the state array is small control state, not storage, so every entry is reset.
      state_q      <= '{default: IDLE};
      io_top_valid <= 1'b0;
      io_top_id    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops sampling pre-edge values regardless of statement order.
      state_q      <= state_d;
      io_top_valid <= |io_pending;
      io_top_id    <= top_id_d;
    end
  end

endmodule

// File: tb/tb_plic_gateway_bank.sv
// Directed bench for plic_gateway_bank: expected outputs queued per stimulus step, popped after each edge.
module tb_plic_gateway_bank;

  localparam int NSRC = 8;
  localparam int IDW  = 4;
`ifdef PLIC_GATEWAY_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [NSRC-1:0] io_src;
  logic            io_claim_valid;
  logic [IDW-1:0]  io_claim_id;
  logic            io_complete_valid;
  logic [IDW-1:0]  io_complete_id;
  logic [NSRC-1:0] io_pending;
  logic [NSRC-1:0] io_inflight;
  logic            io_top_valid;
  logic [IDW-1:0]  io_top_id;

  typedef struct {
    string          tag;
    logic [7:0]     pend;
    logic [7:0]     infl;
    logic           tv;
    logic [IDW-1:0] tid;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prev_pend;
  int         tests  = 0;
  int         failed = 0;

  plic_gateway_bank #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_src           (io_src),
    .io_claim_valid   (io_claim_valid),
    .io_claim_id      (io_claim_id),
    .io_complete_valid(io_complete_valid),
    .io_complete_id   (io_complete_id),
    .io_pending       (io_pending),
    .io_inflight      (io_inflight),
    .io_top_valid     (io_top_valid),
    .io_top_id        (io_top_id)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IDW-1:0] lowest_id(input logic [7:0] p);
    for (int k = 0; k < NSRC; k++) if (p[k]) return IDW'(k + 1);
    return '0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue what the outputs must be after the edge, then pop and compare.
  task automatic step(input logic rst, input logic [7:0] src,
                      input logic cv, input logic [3:0] cid,
                      input logic dv, input logic [3:0] did,
                      input string tag, input logic [7:0] pend, input logic [7:0] infl);
    exp_t e;
    exp_t got;
    reset = rst; io_src = src;
    io_claim_valid = cv; io_claim_id = cid;
    io_complete_valid = dv; io_complete_id = did;
    e.tag  = tag;
    e.pend = pend;
    e.infl = infl;
    e.tv   = rst ? 1'b0 : (prev_pend != 8'h00);
    e.tid  = rst ? '0 : lowest_id(prev_pend);
    sb.push_back(e);
    prev_pend = pend;
    @(posedge clock);
    #1;
    got = sb.pop_front();
    check({got.tag, ".pending"},  io_pending,          got.pend);
    check({got.tag, ".inflight"}, io_inflight,         got.infl);
    check({got.tag, ".top_valid"}, {7'd0, io_top_valid}, {7'd0, got.tv});
    check({got.tag, ".top_id"},   {4'd0, io_top_id},   {4'd0, got.tid});
  endtask

  initial begin
    prev_pend = 8'h00;
    step(1, 8'h00, 0, 0, 0, 0, "rst0", 8'h00, 8'h00);
    step(1, 8'h00, 0, 0, 0, 0, "rst1", 8'h00, 8'h00);
    for (int n = 0; n < 5; n++) step(0, 8'h00, 0, 0, 0, 0, "quiet", 8'h00, 8'h00);

    // Sources 3 and 6: lowest wins, claim 3 moves top to 6.
    step(0, 8'h24, 0, 0, 0, 0, "s36_rise",  8'h24, 8'h00);
    step(0, 8'h24, 0, 0, 0, 0, "s36_top3",  8'h24, 8'h00);
    step(0, 8'h24, 1, 3, 0, 0, "claim3",    8'h20, 8'h04);
    step(0, 8'h24, 0, 0, 0, 0, "top6",      8'h20, 8'h04);
    step(0, 8'h00, 1, 6, 0, 0, "claim6",    8'h00, 8'h24);
    step(0, 8'h00, 0, 0, 1, 3, "complete3", 8'h00, 8'h20);
    step(0, 8'h00, 0, 0, 1, 6, "complete6", 8'h00, 8'h00);

    // Source 1 pulse is held pending until claimed.
    step(0, 8'h01, 0, 0, 0, 0, "s1_pulse",  8'h01, 8'h00);
    step(0, 8'h00, 0, 0, 0, 0, "s1_hold0",  8'h01, 8'h00);
    step(0, 8'h00, 0, 0, 0, 0, "s1_hold1",  8'h01, 8'h00);
    step(0, 8'h00, 1, 1, 0, 0, "claim1",    8'h00, 8'h01);
    step(0, 8'h00, 0, 0, 1, 1, "complete1", 8'h00, 8'h00);
    step(0, 8'h00, 0, 0, 0, 0, "s1_idle",   8'h00, 8'h00);

    // Source 2 held high across claim/complete.
    step(0, 8'h02, 0, 0, 0, 0, "s2_rise",   8'h02, 8'h00);
    step(0, 8'h02, 1, 2, 0, 0, "claim2",    8'h00, 8'h02);
    step(0, 8'h02, 0, 0, 0, 0, "s2_ignore", 8'h00, 8'h02);
    step(0, 8'h02, 0, 0, 1, 2, "complete2", 8'h00, 8'h00);
    step(0, 8'h02, 0, 0, 0, 0, "s2_repend", EDGE ? 8'h00 : 8'h02, 8'h00);
    step(0, 8'h00, 1, 2, 0, 0, "reclaim2",  8'h00, EDGE ? 8'h00 : 8'h02);
    step(0, 8'h00, 0, 0, 1, 2, "recompl2",  8'h00, 8'h00);

    // Simultaneous claim 4 / complete 5, then ignored strobes.
    step(0, 8'h18, 0, 0, 0, 0, "s45_rise",  8'h18, 8'h00);
    step(0, 8'h00, 1, 5, 0, 0, "claim5",    8'h08, 8'h10);
    step(0, 8'h00, 1, 4, 1, 5, "cl4_co5",   8'h00, 8'h08);
    step(0, 8'h80, 0, 0, 0, 0, "s8_rise",   8'h80, 8'h08);
    step(0, 8'h00, 1, 0, 0, 0, "claim_id0", 8'h80, 8'h08);
    step(0, 8'h00, 1, 9, 0, 0, "claim_id9", 8'h80, 8'h08);
    step(0, 8'h00, 0, 0, 1, 8, "compl_pend",8'h80, 8'h08);
    step(0, 8'h00, 1, 15, 1, 0, "cl15_co0", 8'h80, 8'h08);
    step(0, 8'h00, 1, 4, 0, 0, "claim_clm", 8'h80, 8'h08);
    step(0, 8'h00, 0, 0, 1, 4, "complete4", 8'h80, 8'h00);
    step(0, 8'h00, 1, 8, 0, 0, "claim8",    8'h00, 8'h80);
    step(0, 8'h00, 0, 0, 1, 8, "complete8", 8'h00, 8'h00);

    // Source 7: steady high, toggle while claimed, complete.
    step(0, 8'h40, 0, 0, 0, 0, "s7_rise",   8'h40, 8'h00);
    step(0, 8'h40, 0, 0, 0, 0, "s7_steady", 8'h40, 8'h00);
    step(0, 8'h40, 1, 7, 0, 0, "claim7",    8'h00, 8'h40);
    step(0, 8'h00, 0, 0, 0, 0, "s7_low",    8'h00, 8'h40);
    step(0, 8'h40, 0, 0, 0, 0, "s7_rearm",  8'h00, 8'h40);
    step(0, 8'h40, 0, 0, 1, 7, "complete7", EDGE ? 8'h40 : 8'h00, 8'h00);
    step(0, 8'h40, 0, 0, 0, 0, "s7_repend", 8'h40, 8'h00);

    // Reset in the middle of a claim, with strobes active, clears everything.
    step(0, 8'h40, 1, 7, 0, 0, "claim7b",   8'h00, 8'h40);
    step(1, 8'h40, 1, 7, 1, 7, "mid_rst",   8'h00, 8'h00);
    step(0, 8'h00, 0, 0, 0, 0, "post_rst",  8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
